// File: rtl/gpio_irq_arb.sv
// ============================================================================
// gpio_irq_arb : edge-captured, round-robin interrupt arbiter with a
//                claim/complete handshake for GPIO ports A, B and C.
// Revision     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module gpio_irq_arb #(
  parameter int NUM_SRC = 3,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               sel_i,
  input  logic               wr_i,
  input  logic [1:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               ack_o,
  output logic               irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_NOTIFY  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [ID_W:0] C_NUM_SRC = (ID_W+1)'(NUM_SRC);

  state_t              r_state;
  logic [NUM_SRC-1:0]  r_irq_prev;
  logic [NUM_SRC-1:0]  r_pending;
  logic [NUM_SRC-1:0]  r_enable;
  logic [ID_W-1:0]     r_rr;
  logic [ID_W-1:0]     r_cur_id;
  logic                r_in_service;

  logic                w_rd_en;
  logic                w_wr_en;
  logic                w_claim_rd;
  logic                w_complete;
  logic [NUM_SRC-1:0]  w_rise;
  logic [NUM_SRC-1:0]  w_w1c;
  logic [NUM_SRC-1:0]  w_claim_clr;
  logic [NUM_SRC-1:0]  w_cand;
  logic [2*NUM_SRC-1:0] w_dbl_sh;
  logic [NUM_SRC-1:0]  w_rot;
  logic [ID_W:0]       w_off;
  logic [ID_W:0]       w_sum;
  logic [ID_W:0]       w_wrap;
  logic [ID_W:0]       w_inc;
  logic                w_win_vld;
  logic [ID_W-1:0]     w_win_id;
  logic [ID_W-1:0]     w_rr_next;
  logic [31:0]         w_rdata;

  assign w_rd_en     = sel_i & ~wr_i;
  assign w_wr_en     = sel_i & wr_i;
  assign w_claim_rd  = w_rd_en && (addr_i == 2'd2) && (r_state == ST_NOTIFY);
  assign w_complete  = w_wr_en && (addr_i == 2'd2) && (r_state == ST_SERVICE) &&
                       (wdata_i[ID_W-1:0] == r_cur_id);
  assign w_rise      = irq_src_i & ~r_irq_prev;
  assign w_w1c       = (w_wr_en && (addr_i == 2'd1)) ? wdata_i[NUM_SRC-1:0] : '0;
  assign w_claim_clr = w_claim_rd ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << r_cur_id) : '0;
  assign w_cand      = r_pending & r_enable;

  // Rotate the candidates so bit 0 is the rr pointer; the lowest set bit wins.
  assign w_dbl_sh = {w_cand, w_cand} >> r_rr;
  assign w_rot    = w_dbl_sh[NUM_SRC-1:0];

  always_comb begin
    w_win_vld = 1'b0;
    w_off     = '0;
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_win_vld = 1'b1;
        w_off     = (ID_W+1)'(i);
      end
    end
  end

  assign w_sum     = {1'b0, r_rr} + w_off;
  assign w_wrap    = (w_sum >= C_NUM_SRC) ? (w_sum - C_NUM_SRC) : w_sum;
  assign w_win_id  = w_wrap[ID_W-1:0];
  assign w_inc     = {1'b0, r_cur_id} + (ID_W+1)'(1);
  assign w_rr_next = (w_inc >= C_NUM_SRC) ? '0 : w_inc[ID_W-1:0];

  always_comb begin
    w_rdata = '0;
    case (addr_i)
      2'd0: w_rdata[NUM_SRC-1:0] = r_enable;
      2'd1: w_rdata[NUM_SRC-1:0] = r_pending;
      2'd2: begin
        if (r_state == ST_NOTIFY) begin
          w_rdata[31]       = 1'b1;
          w_rdata[ID_W-1:0] = r_cur_id;
        end
      end
      default: begin
        w_rdata[31]       = r_in_service;
        w_rdata[9:8]      = r_state;
        w_rdata[ID_W-1:0] = r_cur_id;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_irq_prev   <= '0;
      r_pending    <= '0;
      r_enable     <= '0;
      r_rr         <= '0;
      r_cur_id     <= '0;
      r_in_service <= 1'b0;
      irq_o        <= 1'b0;
      ack_o        <= 1'b0;
      rdata_o      <= '0;
    end else begin
      r_irq_prev <= irq_src_i;
      // A fresh edge outranks any clear of the same bit in this cycle.
      r_pending  <= (r_pending & ~w_w1c & ~w_claim_clr) | w_rise;
      if (w_wr_en && (addr_i == 2'd0)) begin
        r_enable <= wdata_i[NUM_SRC-1:0];
      end
      ack_o   <= sel_i;
      rdata_o <= w_rd_en ? w_rdata : '0;

      case (r_state)
        ST_IDLE: begin
          if (w_win_vld) begin
            r_cur_id <= w_win_id;
            r_state  <= ST_NOTIFY;
            irq_o    <= 1'b1;
          end
        end
        ST_NOTIFY: begin
          if (w_claim_rd) begin
            r_in_service <= 1'b1;
            r_rr         <= w_rr_next;
            r_state      <= ST_SERVICE;
            irq_o        <= 1'b0;
          end else if (!(r_pending[r_cur_id] && r_enable[r_cur_id])) begin
            r_state <= ST_IDLE;
            irq_o   <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (w_complete) begin
            r_in_service <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          irq_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpio_irq_arb.sv
// ============================================================================
// tb_gpio_irq_arb : scoreboard bench for gpio_irq_arb register and IRQ flow.
// Revision        : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gpio_irq_arb;

  logic        clk;
  logic        rst;
  logic [2:0]  irq_src_i;
  logic        sel_i;
  logic        wr_i;
  logic [1:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        irq_o;

  int n_checks;
  int n_fail;

  string       q_tag[$];
  logic [31:0] q_exp[$];

  gpio_irq_arb #(.NUM_SRC(3), .ID_W(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src_i (irq_src_i),
    .sel_i     (sel_i),
    .wr_i      (wr_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .ack_o     (ack_o),
    .irq_o     (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus access; the expected read data is queued for the ack monitor.
  task automatic acc(input string tag, input logic w, input logic [1:0] a,
                     input logic [31:0] d, input logic [31:0] exp);
    sel_i   = 1'b1;
    wr_i    = w;
    addr_i  = a;
    wdata_i = d;
    q_tag.push_back(tag);
    q_exp.push_back(exp);
    @(negedge clk);
    sel_i   = 1'b0;
    wr_i    = 1'b0;
    wdata_i = '0;
  endtask

  task automatic pulse(input logic [2:0] m);
    irq_src_i = m;
    tick(1);
    irq_src_i = '0;
    tick(1);
  endtask

  always @(negedge clk) begin
    if (ack_o) begin
      if (q_exp.size() == 0) begin
        check("sb_unexpected_ack", 32'd1, 32'd0);
      end else begin
        check(q_tag.pop_front(), rdata_o, q_exp.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    irq_src_i = '0;
    sel_i     = 1'b0;
    wr_i      = 1'b0;
    addr_i    = '0;
    wdata_i   = '0;
    tick(3);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    rst = 1'b0;
    tick(1);
    acc("rst_enable", 1'b0, 2'd0, 0, 32'd0);
    acc("rst_pending", 1'b0, 2'd1, 0, 32'd0);
    acc("rst_status", 1'b0, 2'd3, 0, 32'd0);
    acc("rst_claim", 1'b0, 2'd2, 0, 32'd0);

    // Single source 1: latency, claim, clear
    acc("wr_en7", 1'b1, 2'd0, 32'd7, 32'd0);
    irq_src_i = 3'b010;
    tick(1);
    irq_src_i = '0;
    check("t1_irq_e0", {31'd0, irq_o}, 32'd0);
    acc("t1_pending", 1'b0, 2'd1, 0, 32'd2);
    check("t1_irq_e1", {31'd0, irq_o}, 32'd1);
    acc("t1_claim", 1'b0, 2'd2, 0, 32'h8000_0001);
    check("t1_irq_after_claim", {31'd0, irq_o}, 32'd0);
    acc("t1_pend_clr", 1'b0, 2'd1, 0, 32'd0);
    acc("t1_status_svc", 1'b0, 2'd3, 0, 32'h8000_0201);
    acc("t1_complete", 1'b1, 2'd2, 32'd1, 32'd0);
    acc("t1_status_idle", 1'b0, 2'd3, 0, 32'h0000_0001);

    // Move rr to 0 by servicing id 2
    pulse(3'b100);
    acc("t2_claim_pre", 1'b0, 2'd2, 0, 32'h8000_0002);
    acc("t2_cpl_pre", 1'b1, 2'd2, 32'd2, 32'd0);

    // All three at once: round-robin order 0,1,2
    pulse(3'b111);
    check("t2_irq0", {31'd0, irq_o}, 32'd1);
    acc("t2_claim0", 1'b0, 2'd2, 0, 32'h8000_0000);
    acc("t2_cpl0", 1'b1, 2'd2, 32'd0, 32'd0);
    tick(1);
    check("t2_irq1", {31'd0, irq_o}, 32'd1);
    acc("t2_claim1", 1'b0, 2'd2, 0, 32'h8000_0001);
    acc("t2_cpl_bad", 1'b1, 2'd2, 32'd3, 32'd0);
    acc("t2_status_bad", 1'b0, 2'd3, 0, 32'h8000_0201);
    acc("t2_cpl1", 1'b1, 2'd2, 32'd1, 32'd0);
    tick(1);
    check("t2_irq2", {31'd0, irq_o}, 32'd1);
    acc("t2_claim2", 1'b0, 2'd2, 0, 32'h8000_0002);
    acc("t2_cpl2", 1'b1, 2'd2, 32'd2, 32'd0);

    // Masked source, then enabled
    acc("t3_en3", 1'b1, 2'd0, 32'd3, 32'd0);
    pulse(3'b100);
    tick(2);
    check("t3_irq_masked", {31'd0, irq_o}, 32'd0);
    acc("t3_pending", 1'b0, 2'd1, 0, 32'd4);
    acc("t3_en4", 1'b1, 2'd0, 32'd4, 32'd0);
    check("t3_irq_n1", {31'd0, irq_o}, 32'd0);
    tick(1);
    check("t3_irq_n2", {31'd0, irq_o}, 32'd1);
    acc("t3_claim", 1'b0, 2'd2, 0, 32'h8000_0002);
    acc("t3_cpl", 1'b1, 2'd2, 32'd2, 32'd0);

    // W1C during NOTIFY withdraws the request
    acc("t4_en_all", 1'b1, 2'd0, 32'hFFFF_FFFF, 32'd0);
    acc("t4_en_rd", 1'b0, 2'd0, 0, 32'd7);
    pulse(3'b001);
    check("t4_irq_notify", {31'd0, irq_o}, 32'd1);
    acc("t4_w1c", 1'b1, 2'd1, 32'd1, 32'd0);
    tick(1);
    check("t4_irq_drop", {31'd0, irq_o}, 32'd0);
    acc("t4_claim_none", 1'b0, 2'd2, 0, 32'd0);
    acc("t4_status", 1'b0, 2'd3, 0, 32'd0);

    // Edge and W1C in the same cycle: set wins
    acc("t5_en0", 1'b1, 2'd0, 32'd0, 32'd0);
    irq_src_i = 3'b001;
    acc("t5_w1c", 1'b1, 2'd1, 32'd1, 32'd0);
    irq_src_i = '0;
    acc("t5_pending", 1'b0, 2'd1, 0, 32'd1);
    acc("t5_w1c2", 1'b1, 2'd1, 32'd1, 32'd0);
    acc("t5_pending_clr", 1'b0, 2'd1, 0, 32'd0);

    // Source held high through reset release
    irq_src_i = 3'b100;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    acc("t6_pending", 1'b0, 2'd1, 0, 32'd4);
    irq_src_i = '0;
    check("t6_irq_masked", {31'd0, irq_o}, 32'd0);
    acc("t6_en7", 1'b1, 2'd0, 32'd7, 32'd0);
    tick(1);
    check("t6_irq_notify", {31'd0, irq_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_irq_async", {31'd0, irq_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    acc("t6_status", 1'b0, 2'd3, 0, 32'd0);

    // Reset during SERVICE
    acc("t7_en7", 1'b1, 2'd0, 32'd7, 32'd0);
    pulse(3'b010);
    acc("t7_claim", 1'b0, 2'd2, 0, 32'h8000_0001);
    acc("t7_status_svc", 1'b0, 2'd3, 0, 32'h8000_0201);
    rst = 1'b1;
    #1;
    check("t7_irq_rst", {31'd0, irq_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    acc("t7_status", 1'b0, 2'd3, 0, 32'd0);
    acc("t7_enable", 1'b0, 2'd0, 0, 32'd0);
    acc("t7_pending", 1'b0, 2'd1, 0, 32'd0);

    tick(3);
    check("sb_drain", q_exp.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
